// File: rtl/eeprom_ctrl.sv
// Sequencing controller for a 16x16 EEPROM array: runs erase/write strobe
// windows, reads the word back, and reports data plus a verify-error flag.
module eeprom_ctrl #(
    parameter int ERASE_CYCLES = 4,
    parameter int WRITE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic [7:0]  err_count,
    output logic [3:0]  mem_addr,
    output logic        mem_we,
    output logic        mem_erase,
    output logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out
);

    typedef enum logic [2:0] {IDLE, ERASE, WRITE, READ, VERIFY, RESP} state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b10;
    localparam logic [1:0] OP_PROG  = 2'b11;

    // Counters are loaded with N-1 so each strobe window is exactly N cycles.
    localparam logic [3:0] E_LOAD = 4'(ERASE_CYCLES - 1);
    localparam logic [3:0] W_LOAD = 4'(WRITE_CYCLES - 1);

    state_t      state, state_nx;
    logic [1:0]  op;
    logic [15:0] expected;
    logic [3:0]  cnt;
    logic        accept;
    logic        mismatch;

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign mem_we    = (state == WRITE);
    assign mem_erase = (state == ERASE);
    assign accept    = cmd_valid & cmd_ready;
    assign mismatch  = (mem_data_out != expected);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_READ:  state_nx = READ;
                        OP_WRITE: state_nx = WRITE;
                        default:  state_nx = ERASE;
                    endcase
                end
            end
            ERASE:   if (cnt == 4'd0) state_nx = (op == OP_PROG) ? WRITE : VERIFY;
            WRITE:   if (cnt == 4'd0) state_nx = VERIFY;
            READ:    state_nx = RESP;
            VERIFY:  state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op          <= OP_READ;
            expected    <= '0;
            cnt         <= '0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            err_count   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op          <= cmd_op;
                        mem_addr    <= cmd_addr;
                        mem_data_in <= cmd_wdata;
                        expected    <= (cmd_op == OP_ERASE) ? 16'h0000 : cmd_wdata;
                        cnt         <= (cmd_op == OP_WRITE) ? W_LOAD : E_LOAD;
                    end
                end
                ERASE:  cnt <= (cnt == 4'd0) ? W_LOAD : cnt - 4'd1;
                WRITE:  if (cnt != 4'd0) cnt <= cnt - 4'd1;
                READ: begin
                    rsp_rdata <= mem_data_out;
                    rsp_err   <= 1'b0;
                end
                VERIFY: begin
                    rsp_rdata <= mem_data_out;
                    rsp_err   <= mismatch;
                    if (mismatch && err_count != 8'hFF) err_count <= err_count + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eeprom_ctrl.sv
// Bench for eeprom_ctrl: behavioural 16x16 array, vector table of commands,
// response scoreboard, plus backpressure, saturation and mid-write reset cases.
module tb_eeprom_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  err_count;
    logic [3:0]  mem_addr;
    logic        mem_we, mem_erase;
    logic [15:0] mem_data_in, mem_data_out;

    eeprom_ctrl #(.ERASE_CYCLES(4), .WRITE_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .err_count(err_count),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_erase(mem_erase),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // Array model: word i powers up as 0x0010+i; 'bad' corrupts the read port.
    logic [15:0] mem [16];
    logic        init_mem;
    logic        bad;
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'h0010 + 16'(i);
        end else if (mem_erase) mem[mem_addr] <= 16'h0000;
        else if (mem_we)        mem[mem_addr] <= mem_data_in;
    end
    assign mem_data_out = bad ? 16'h1234 : mem[mem_addr];

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic        bad;
        int          hold;
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          lat;
        int          n_erase;
        int          n_we;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          exp_ec = 0;
    logic [16:0] sb_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_cmd(input vec_t v);
        int k, n_er, n_we, first_we, ovl, addr_bad, data_bad;
        logic [15:0] r0;
        logic        e0;
        logic [16:0] exp_rsp;
        bad = v.bad;
        cmd_op = v.op; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
        if (!cmd_ready) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        sb_q.push_back({v.exp_rdata, v.exp_err});
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 1; n_er = 0; n_we = 0; first_we = 0; ovl = 0; addr_bad = 0; data_bad = 0;
        while (!rsp_valid && k < 100) begin
            if (mem_erase) n_er++;
            if (mem_we) begin
                n_we++;
                if (first_we == 0) first_we = k;
                if (mem_data_in != v.wdata) data_bad++;
            end
            if (mem_we && mem_erase) ovl++;
            if ((mem_we || mem_erase) && mem_addr != v.addr) addr_bad++;
            @(negedge clk);
            k++;
        end
        chk("latency", k, v.lat);
        chk("erase_cycles", n_er, v.n_erase);
        chk("we_cycles", n_we, v.n_we);
        if (v.n_we > 0) chk("we_start", first_we, v.n_erase + 1);
        chk("strobe_overlap", ovl, 0);
        chk("mem_addr_hold", addr_bad, 0);
        chk("mem_data_in_hold", data_bad, 0);
        r0 = rsp_rdata; e0 = rsp_err;
        if (v.hold > 0) begin
            cmd_op = 2'b00; cmd_addr = 4'd0; cmd_valid = 1'b1;
        end
        for (int h = 0; h < v.hold; h++) begin
            chk("bp_valid", int'(rsp_valid), 1);
            chk("bp_rdata", int'(rsp_rdata), int'(r0));
            chk("bp_err", int'(rsp_err), int'(e0));
            chk("bp_cmd_ready", int'(cmd_ready), 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        if (sb_q.size() == 0) chk("sb_empty", 0, 1);
        else begin
            exp_rsp = sb_q.pop_front();
            chk("rsp_rdata", int'(rsp_rdata), int'(exp_rsp[16:1]));
            chk("rsp_err", int'(rsp_err), int'(exp_rsp[0]));
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("rsp_drop", int'(rsp_valid), 0);
        chk("ready_after_hs", int'(cmd_ready), 1);
        if (v.exp_err && exp_ec < 255) exp_ec++;
        chk("err_count", int'(err_count), exp_ec);
        bad = 1'b0;
    endtask

    vec_t tbl[9];
    vec_t vf;

    initial begin
        tbl[0] = '{2'b00, 4'd3,  16'h0000, 1'b0, 0, 16'h0013, 1'b0, 2,  0, 0};
        tbl[1] = '{2'b11, 4'd5,  16'hBEEF, 1'b0, 6, 16'hBEEF, 1'b0, 10, 4, 4};
        tbl[2] = '{2'b00, 4'd5,  16'h0000, 1'b0, 0, 16'hBEEF, 1'b0, 2,  0, 0};
        tbl[3] = '{2'b10, 4'd15, 16'hFFFF, 1'b0, 0, 16'h0000, 1'b0, 6,  4, 0};
        tbl[4] = '{2'b00, 4'd15, 16'h0000, 1'b0, 0, 16'h0000, 1'b0, 2,  0, 0};
        tbl[5] = '{2'b01, 4'd7,  16'hA5A5, 1'b0, 2, 16'hA5A5, 1'b0, 6,  0, 4};
        tbl[6] = '{2'b01, 4'd9,  16'hBEEF, 1'b1, 0, 16'h1234, 1'b1, 6,  0, 4};
        tbl[7] = '{2'b00, 4'd9,  16'h0000, 1'b1, 0, 16'h1234, 1'b0, 2,  0, 0};
        tbl[8] = '{2'b00, 4'd9,  16'h0000, 1'b0, 0, 16'hBEEF, 1'b0, 2,  0, 0};

        rst = 1'b1; init_mem = 1'b1; bad = 1'b0;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 4'd0; cmd_wdata = 16'h0000;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_rdata", int'(rsp_rdata), 0);
        chk("rst_rsp_err", int'(rsp_err), 0);
        chk("rst_err_count", int'(err_count), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_mem_erase", int'(mem_erase), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_data_in", int'(mem_data_in), 0);
        rst = 1'b0; init_mem = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_cmd(tbl[i]);

        // Early rsp_ready must not create a response.
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("early_rsp_ready", int'(rsp_valid), 0);
        rsp_ready = 1'b0;

        vf = '{2'b01, 4'd2, 16'hBEEF, 1'b1, 0, 16'h1234, 1'b1, 6, 0, 4};
        for (int i = 0; i < 300; i++) run_cmd(vf);
        chk("err_count_sat", int'(err_count), 255);

        // Reset during the second WRITE cycle.
        cmd_op = 2'b01; cmd_addr = 4'd4; cmd_wdata = 16'h5555; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mw_we_c1", int'(mem_we), 1);
        @(negedge clk);
        chk("mw_we_c2", int'(mem_we), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mw_we_drop", int'(mem_we), 0);
        chk("mw_cmd_ready", int'(cmd_ready), 1);
        chk("mw_rsp_valid", int'(rsp_valid), 0);
        chk("mw_err_count", int'(err_count), 0);
        rst = 1'b0;
        exp_ec = 0;
        sb_q.delete();
        @(negedge clk);

        run_cmd(tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/eeprom_ctrl.md
Name: eeprom_ctrl

Overview:
- Sequencing controller that sits directly upstream of the 16x16 EEPROM array.
- Accepts read, write, erase and program (erase-then-write) commands over a valid/ready host interface.
- Drives the array's level-sensitive addr/we/erase/data_in strobes for a parameterised number of cycles, then reads back data_out.
- Returns the read data plus a verify-error flag over a valid/ready response channel, and keeps a saturating error counter.

Parameters:
- ERASE_CYCLES, 4, cycles mem_erase is held high per erase; legal range 1..15.
- WRITE_CYCLES, 4, cycles mem_we is held high per write; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  command opcode: 00 READ, 01 WRITE, 10 ERASE, 11 PROGRAM.
- cmd_addr  in  4  target word address.
- cmd_wdata  in  16  write data; ignored for READ and ERASE.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  host accepts the response.
- rsp_rdata  out  16  word read back from the array.
- rsp_err  out  1  verify mismatch; always 0 for READ.
- err_count  out  8  saturating count of verify mismatches.
- mem_addr  out  4  array address.
- mem_we  out  1  array write strobe.
- mem_erase  out  1  array erase strobe.
- mem_data_in  out  16  array write data.
- mem_data_out  in  16  array read data (combinational from mem_addr).

Behaviour:
- Reset, synchronous and active-high on rst:
  - state=IDLE; cmd_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; err_count=0.
  - mem_we=0; mem_erase=0; mem_addr=0; mem_data_in=0.
- mem_we and mem_erase are pure decodes of the registered state (mem_we = state==WRITE, mem_erase = state==ERASE), so they are glitch-free and never high together.
- mem_addr and mem_data_in are latched at command accept and held stable until the next accept.
- FSM states are IDLE, ERASE, WRITE, READ, VERIFY, RESP.
  - cmd_ready=1 only in IDLE.
  - A handshake (cmd_valid & cmd_ready) on cycle T latches op, addr and wdata.
  - The expected value is wdata for WRITE/PROGRAM and 0x0000 for ERASE.
- IDLE -> READ (op 00), WRITE (op 01), or ERASE (op 10 and 11) at T+1.
- ERASE: held for exactly ERASE_CYCLES cycles using a down-counter. Exit to WRITE if op=PROGRAM, else to VERIFY.
- WRITE: held for exactly WRITE_CYCLES cycles, then VERIFY.
- READ: one settling cycle with both strobes low; on exit, sample mem_data_out into rsp_rdata, set rsp_err=0, go to RESP.
- VERIFY: one cycle with both strobes low; sample mem_data_out into rsp_rdata, set rsp_err = (mem_data_out != expected), go to RESP.
  - On a mismatch, err_count increments and saturates at 255.
- RESP: rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready. On the handshake cycle, next state is IDLE and rsp_valid drops at the next edge.
- Latency from accept cycle T to first rsp_valid cycle:
  - READ: T+2.
  - WRITE: T+W+2.
  - ERASE: T+E+2.
  - PROGRAM: T+E+W+2.
- Throughput: a new command can be accepted no earlier than the cycle after the response handshake; there is no command/response overlap.
- cmd_valid while busy: ignored (cmd_ready=0); the host must hold its command.
- rsp_ready high before rsp_valid has no effect.
- Reset mid-operation: strobes drop at the same edge as reset. The interrupted word's content is undefined. err_count clears.
- No illegal opcodes exist; all four encodings are defined.

Test Plan:
- Reset, then READ addr 3 with the array holding init value 0x0013 -> rsp_valid at T+2, rsp_rdata=0x0013, rsp_err=0, mem_we and mem_erase never high.
- PROGRAM addr 5 with wdata 0xBEEF, default parameters:
  - mem_erase high T+1..T+4; mem_we high T+5..T+8 with mem_addr=5 throughout.
  - rsp_valid at T+10 with rsp_rdata=0xBEEF and rsp_err=0.
  - A follow-up READ addr 5 returns 0xBEEF.
- ERASE addr 15 -> mem_erase high 4 cycles, rsp_rdata=0x0000, rsp_err=0. A subsequent READ returns 0x0000.
- Backpressure: hold rsp_ready=0 for 6 cycles during RESP -> rsp_valid, rsp_rdata and rsp_err stable; cmd_ready=0; a second cmd_valid is not accepted until one cycle after the handshake.
- Verify failure: bench model forces mem_data_out=0x1234 during VERIFY of WRITE 0xBEEF -> rsp_err=1, err_count 0->1. Repeat 300 failures -> err_count holds at 255.
- Assert rst in the 2nd WRITE cycle -> mem_we=0 from the next edge, state IDLE, cmd_ready=1, rsp_valid=0, err_count=0.
